id_issue: RTL and testbench
===========================

# id_issue

Instruction-decode/issue stage of the MIPS pipeline. It takes the IF/ID instruction word and register-file read data and decodes the opcode/funct into the 5-bit ALUOp and operand pair the ALU consumes. It detects RAW and load-use hazards and inserts bubbles. It drives the registered ID/EX pipeline boundary under a valid/ready handshake with stall and flush.

## Interface
- No parameters; widths fixed by the MIPS32 datapath.
- clk  in  1  pipeline clock, rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  IF/ID holds an instruction
- id_ready  out  1  issue accepts the IF/ID instruction this cycle
- id_instr  in  32  instruction word
- id_pc  in  32  instruction PC
- rs_data / rt_data  in  32  register-file reads of instr[25:21] / instr[20:16]; write-through on WB
- ex_ready  in  1  EX stage can accept; low holds the ID/EX register
- flush  in  1  kill the instruction in ID (taken branch)
- mem_we  in  1  EX/MEM stage writes a register
- mem_wreg  in  5  EX/MEM destination
- mem_data  in  32  EX/MEM writeback value, load data included (FORWARD_EN only)
- ex_valid  out  1  ID/EX holds a real instruction
- ex_aluop  out  5  ALUOp to ALU
- ex_a / ex_b  out  32  ALU operands A, B
- ex_wreg  out  5  destination register
- ex_we  out  1  register write enable
- ex_mem_rd / ex_mem_wr  out  1  load / store
- ex_store_data  out  32  store data (rt)
- ex_branch  out  1  conditional branch; taken iff ALU result == 0
- ex_illegal  out  1  unsupported encoding, issued as NOP
- ex_pc  out  32  PC of issued instruction

## Operation
- ALUOP codes come from ctrl_def.v: ADD=0, SUB=1, SLL=2, SRL=3, SRA=4, AND=5, OR=6, XOR=7, NOR=8, SLT=9, SLTU=10, LUI=11, BNE=12, BLEZ=13, BGTZ=14, BLTZ=15, BGEZ=16.
- R-type decode:
  - ADD/ADDU→ADD; SUB/SUBU→SUB; AND, OR, XOR, NOR, SLT, SLTU→same-named ALUOP.
  - A=rs, B=rt, wreg=rd.
  - SLL/SRL/SRA: A={27'b0,shamt}, B=rt.
  - SLLV/SRLV/SRAV: A=rs, B=rt.
- I-type decode: wreg=rt, A=rs.
  - ADDI/ADDIU→ADD, SLTI→SLT, SLTIU→SLTU, each with B=sign-extended imm.
  - ANDI/ORI/XORI: B=zero-extended imm.
  - LUI→LUI with B={16'b0,imm}.
  - LW→ADD with sign-extended imm, mem_rd=1.
  - SW→ADD with sign-extended imm, mem_wr=1, we=0, store_data=rt.
- Branch decode: we=0, branch=1.
  - BEQ→SUB with A=rs, B=rt; BNE→BNE.
  - BLEZ→BLEZ; BGTZ→BGTZ.
  - REGIMM rt=0→BLTZ; rt=1→BGEZ.
- Writes to register 0 force ex_we=0.
- Any other encoding: ex_illegal=1, ALUOP_ADD, all enables 0.
- Register 0 never hazards or forwards.
- Load-use hazard: ex_valid & ex_mem_rd & ex_wreg≠0 & ex_wreg matches a source actually read.

## Timing
- Reset: all outputs 0 (ex_aluop=ADD). id_ready is 0 during rst.
- id_ready = ex_ready & ~hazard & ~rst. A transfer occurs when id_valid & id_ready. Latency is one cycle to the ID/EX outputs.
- ex_ready=0: all ID/EX outputs hold; id_ready=0.
- Hazard with ex_ready=1: bubble loaded (ex_valid=0, we/mem/branch=0); the instruction stays in ID and retries next cycle.
- flush=1: next-cycle ex_valid=0 regardless of ex_ready or hazard; the ID instruction is dropped (id_ready=1 so IF/ID advances). flush has priority over every other condition.
- id_valid=0 with ex_ready=1: bubble.

## Configuration
- FORWARD_EN defined:
  - mem_data port exists.
  - Sources matching a valid mem_we/mem_wreg take mem_data (EX/MEM has priority over rs_data/rt_data).
  - Only load-use against ID/EX stalls (exactly one bubble).
- FORWARD_EN undefined:
  - No mem_data port.
  - Any source matching the ID/EX destination (ex_valid&ex_we) or EX/MEM destination (mem_we) stalls until clear.

## Structure
- ALUOP_* codes, opcode/funct constants and REGIMM rt codes live in the shared ctrl_def.v.
- One sub-module, id_decode: purely combinational instr→control fields.
- id_issue holds the hazard logic, forwarding muxes and ID/EX register.

## Test plan
- add $10,$8,$9 (0x01095020), rs=5, rt=7 → next cycle: ex_valid=1, aluop=0, a=5, b=7, wreg=10, we=1.
- sra $3,$4,2 (0x00041883), rt=0x80000000 → aluop=4, a=2, b=0x80000000, wreg=3.
- andi $5,$6,0xFFFF (0x30C5FFFF) → aluop=5, b=0x0000FFFF. addi $5,$0,-1 (0x2005FFFF) → aluop=0, b=0xFFFFFFFF.
- lw $8,0($9) (0x8D280000) then 0x01095020 → id_ready=0 for one cycle, one bubble (ex_valid=0), then the add issues. Without FORWARD_EN: two bubbles.
- ex_ready=0 for 3 cycles mid-stream → outputs frozen, id_ready=0. flush with id_valid=1 → ex_valid=0 next cycle. rst mid-stream → all outputs 0 next cycle.
- Illegal opcode 0x3F → ex_illegal=1, we=0. Write to $0 (0x00000020, add $0,$0,$0) → we=0.

Source files
------------

// File: rtl/id_issue_pkg.sv
// Shared ALUOp codes, MIPS opcode/funct/REGIMM constants and the ID/EX register layout
// used by the decode/issue stage.
package id_issue_pkg;

    localparam logic [4:0] ALUOP_ADD  = 5'd0;
    localparam logic [4:0] ALUOP_SUB  = 5'd1;
    localparam logic [4:0] ALUOP_SLL  = 5'd2;
    localparam logic [4:0] ALUOP_SRL  = 5'd3;
    localparam logic [4:0] ALUOP_SRA  = 5'd4;
    localparam logic [4:0] ALUOP_AND  = 5'd5;
    localparam logic [4:0] ALUOP_OR   = 5'd6;
    localparam logic [4:0] ALUOP_XOR  = 5'd7;
    localparam logic [4:0] ALUOP_NOR  = 5'd8;
    localparam logic [4:0] ALUOP_SLT  = 5'd9;
    localparam logic [4:0] ALUOP_SLTU = 5'd10;
    localparam logic [4:0] ALUOP_LUI  = 5'd11;
    localparam logic [4:0] ALUOP_BNE  = 5'd12;
    localparam logic [4:0] ALUOP_BLEZ = 5'd13;
    localparam logic [4:0] ALUOP_BGTZ = 5'd14;
    localparam logic [4:0] ALUOP_BLTZ = 5'd15;
    localparam logic [4:0] ALUOP_BGEZ = 5'd16;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_SLTIU  = 6'h0B;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_XORI   = 6'h0E;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    localparam logic [4:0] RT_BLTZ = 5'd0;
    localparam logic [4:0] RT_BGEZ = 5'd1;

    typedef enum logic [1:0] {A_RS, A_SHAMT, A_ZERO} asel_e;
    typedef enum logic [1:0] {B_RT, B_IMM, B_ZERO} bsel_e;

    // All-zero value of this struct is the bubble (aluop ADD, every enable low).
    typedef struct packed {
        logic        valid;
        logic [4:0]  aluop;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  wreg;
        logic        we;
        logic        mem_rd;
        logic        mem_wr;
        logic [31:0] store_data;
        logic        branch;
        logic        illegal;
        logic [31:0] pc;
    } idex_t;

endpackage

// File: rtl/id_decode.sv
// Purely combinational MIPS32 decoder: instruction word to ALUOp, operand selects,
// destination/enables and the register sources actually read (0 = none).
module id_decode
    import id_issue_pkg::*;
(
    input  logic [31:0] instr,
    output logic [4:0]  aluop,
    output logic [1:0]  a_sel,
    output logic [1:0]  b_sel,
    output logic [31:0] imm,
    output logic [4:0]  shamt,
    output logic [4:0]  wreg,
    output logic        we,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        branch,
    output logic        illegal,
    output logic [4:0]  src_rs,
    output logic [4:0]  src_rt
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       zext;
    logic       rd_rs;
    logic       rd_rt;
    logic       bad;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign shamt  = instr[10:6];
    assign imm    = zext ? {16'b0, instr[15:0]} : {{16{instr[15]}}, instr[15:0]};
    assign src_rs = rd_rs ? instr[25:21] : 5'd0;
    assign src_rt = rd_rt ? rt : 5'd0;

    always_comb begin
        aluop   = ALUOP_ADD;
        a_sel   = A_RS;
        b_sel   = B_RT;
        zext    = 1'b0;
        wreg    = 5'd0;
        we      = 1'b0;
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        branch  = 1'b0;
        illegal = 1'b0;
        rd_rs   = 1'b0;
        rd_rt   = 1'b0;
        bad     = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                wreg  = rd;
                we    = 1'b1;
                rd_rs = 1'b1;
                rd_rt = 1'b1;
                case (funct)
                    FN_ADD, FN_ADDU: aluop = ALUOP_ADD;
                    FN_SUB, FN_SUBU: aluop = ALUOP_SUB;
                    FN_AND:  aluop = ALUOP_AND;
                    FN_OR:   aluop = ALUOP_OR;
                    FN_XOR:  aluop = ALUOP_XOR;
                    FN_NOR:  aluop = ALUOP_NOR;
                    FN_SLT:  aluop = ALUOP_SLT;
                    FN_SLTU: aluop = ALUOP_SLTU;
                    // Immediate shifts put shamt on A, so rs is not a real source.
                    FN_SLL:  begin aluop = ALUOP_SLL; a_sel = A_SHAMT; rd_rs = 1'b0; end
                    FN_SRL:  begin aluop = ALUOP_SRL; a_sel = A_SHAMT; rd_rs = 1'b0; end
                    FN_SRA:  begin aluop = ALUOP_SRA; a_sel = A_SHAMT; rd_rs = 1'b0; end
                    FN_SLLV: aluop = ALUOP_SLL;
                    FN_SRLV: aluop = ALUOP_SRL;
                    FN_SRAV: aluop = ALUOP_SRA;
                    default: bad = 1'b1;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LW: begin
                wreg  = rt;
                we    = 1'b1;
                rd_rs = 1'b1;
                b_sel = B_IMM;
                case (opcode)
                    OP_SLTI:  aluop = ALUOP_SLT;
                    OP_SLTIU: aluop = ALUOP_SLTU;
                    OP_ANDI:  begin aluop = ALUOP_AND; zext = 1'b1; end
                    OP_ORI:   begin aluop = ALUOP_OR;  zext = 1'b1; end
                    OP_XORI:  begin aluop = ALUOP_XOR; zext = 1'b1; end
                    OP_LW:    mem_rd = 1'b1;
                    default:  aluop = ALUOP_ADD;
                endcase
            end
            OP_LUI: begin
                aluop = ALUOP_LUI;
                b_sel = B_IMM;
                zext  = 1'b1;
                wreg  = rt;
                we    = 1'b1;
            end
            OP_SW: begin
                b_sel  = B_IMM;
                wreg   = rt;
                mem_wr = 1'b1;
                rd_rs  = 1'b1;
                rd_rt  = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                aluop  = (opcode == OP_BEQ) ? ALUOP_SUB : ALUOP_BNE;
                branch = 1'b1;
                rd_rs  = 1'b1;
                rd_rt  = 1'b1;
            end
            OP_BLEZ, OP_BGTZ: begin
                aluop  = (opcode == OP_BLEZ) ? ALUOP_BLEZ : ALUOP_BGTZ;
                b_sel  = B_ZERO;
                branch = 1'b1;
                rd_rs  = 1'b1;
            end
            OP_REGIMM: begin
                b_sel  = B_ZERO;
                branch = 1'b1;
                rd_rs  = 1'b1;
                case (rt)
                    RT_BLTZ: aluop = ALUOP_BLTZ;
                    RT_BGEZ: aluop = ALUOP_BGEZ;
                    default: bad = 1'b1;
                endcase
            end
            default: bad = 1'b1;
        endcase

        if (bad) begin
            aluop   = ALUOP_ADD;
            a_sel   = A_ZERO;
            b_sel   = B_ZERO;
            zext    = 1'b0;
            wreg    = 5'd0;
            we      = 1'b0;
            mem_rd  = 1'b0;
            mem_wr  = 1'b0;
            branch  = 1'b0;
            illegal = 1'b1;
            rd_rs   = 1'b0;
            rd_rt   = 1'b0;
        end
        if (wreg == 5'd0) we = 1'b0;
    end

endmodule

// File: rtl/id_issue.sv
// MIPS decode/issue stage: hazard detection, optional EX/MEM forwarding and the ID/EX
// register. Define FORWARD_EN to add the mem_data port and forward instead of stalling.
module id_issue
    import id_issue_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    output logic        id_ready,
    input  logic [31:0] id_instr,
    input  logic [31:0] id_pc,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        ex_ready,
    input  logic        flush,
    input  logic        mem_we,
    input  logic [4:0]  mem_wreg,
`ifdef FORWARD_EN
    input  logic [31:0] mem_data,
`endif
    output logic        ex_valid,
    output logic [4:0]  ex_aluop,
    output logic [31:0] ex_a,
    output logic [31:0] ex_b,
    output logic [4:0]  ex_wreg,
    output logic        ex_we,
    output logic        ex_mem_rd,
    output logic        ex_mem_wr,
    output logic [31:0] ex_store_data,
    output logic        ex_branch,
    output logic        ex_illegal,
    output logic [31:0] ex_pc
);

    logic [4:0]  d_aluop, d_shamt, d_wreg, src_rs, src_rt;
    logic [1:0]  d_a_sel, d_b_sel;
    logic [31:0] d_imm;
    logic        d_we, d_mem_rd, d_mem_wr, d_branch, d_illegal;

    id_decode u_decode (
        .instr   (id_instr),
        .aluop   (d_aluop),
        .a_sel   (d_a_sel),
        .b_sel   (d_b_sel),
        .imm     (d_imm),
        .shamt   (d_shamt),
        .wreg    (d_wreg),
        .we      (d_we),
        .mem_rd  (d_mem_rd),
        .mem_wr  (d_mem_wr),
        .branch  (d_branch),
        .illegal (d_illegal),
        .src_rs  (src_rs),
        .src_rt  (src_rt)
    );

    idex_t       idex_q;
    idex_t       issue;
    logic [31:0] rs_val, rt_val;
    logic        rs_ex_hit, rt_ex_hit, rs_mem_hit, rt_mem_hit, hazard;

    // src_* is 0 when the field is not read, so register 0 never hazards or forwards.
    assign rs_ex_hit  = (src_rs != 5'd0) && idex_q.valid && (idex_q.wreg == src_rs);
    assign rt_ex_hit  = (src_rt != 5'd0) && idex_q.valid && (idex_q.wreg == src_rt);
    assign rs_mem_hit = (src_rs != 5'd0) && mem_we && (mem_wreg == src_rs);
    assign rt_mem_hit = (src_rt != 5'd0) && mem_we && (mem_wreg == src_rt);

`ifdef FORWARD_EN
    assign rs_val = rs_mem_hit ? mem_data : rs_data;
    assign rt_val = rt_mem_hit ? mem_data : rt_data;
    assign hazard = idex_q.mem_rd && (rs_ex_hit || rt_ex_hit);
`else
    assign rs_val = rs_data;
    assign rt_val = rt_data;
    assign hazard = (idex_q.we && (rs_ex_hit || rt_ex_hit)) || rs_mem_hit || rt_mem_hit;
`endif

    // Handshake: IF/ID -> ID/EX transfers on a rising edge where id_valid && id_ready.
    // id_ready never depends on id_valid. A flush always accepts (and drops) the ID
    // instruction; otherwise ex_ready low freezes ID/EX and a hazard loads a bubble.
    assign id_ready = !rst && (flush || (ex_ready && !hazard));

    always_comb begin
        issue            = '0;
        issue.valid      = 1'b1;
        issue.aluop      = d_aluop;
        issue.wreg       = d_wreg;
        issue.we         = d_we;
        issue.mem_rd     = d_mem_rd;
        issue.mem_wr     = d_mem_wr;
        issue.store_data = rt_val;
        issue.branch     = d_branch;
        issue.illegal    = d_illegal;
        issue.pc         = id_pc;
        case (d_a_sel)
            A_SHAMT: issue.a = {27'b0, d_shamt};
            A_ZERO:  issue.a = 32'd0;
            default: issue.a = rs_val;
        endcase
        case (d_b_sel)
            B_IMM:   issue.b = d_imm;
            B_ZERO:  issue.b = 32'd0;
            default: issue.b = rt_val;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            idex_q <= '0;
        end else if (ex_ready) begin
            idex_q <= (id_valid && !hazard) ? issue : '0;
        end
    end

    assign ex_valid      = idex_q.valid;
    assign ex_aluop      = idex_q.aluop;
    assign ex_a          = idex_q.a;
    assign ex_b          = idex_q.b;
    assign ex_wreg       = idex_q.wreg;
    assign ex_we         = idex_q.we;
    assign ex_mem_rd     = idex_q.mem_rd;
    assign ex_mem_wr     = idex_q.mem_wr;
    assign ex_store_data = idex_q.store_data;
    assign ex_branch     = idex_q.branch;
    assign ex_illegal    = idex_q.illegal;
    assign ex_pc         = idex_q.pc;

endmodule

// File: tb/tb_id_issue.sv
// Directed self-checking bench for id_issue; works with or without FORWARD_EN defined.
module tb_id_issue;

    logic        clk = 1'b0;
    logic        rst, id_valid, ex_ready, flush, mem_we;
    logic [31:0] id_instr, id_pc, rs_data, rt_data;
    logic [4:0]  mem_wreg;
`ifdef FORWARD_EN
    logic [31:0] mem_data;
`endif
    logic        id_ready, ex_valid, ex_we, ex_mem_rd, ex_mem_wr, ex_branch, ex_illegal;
    logic [4:0]  ex_aluop, ex_wreg;
    logic [31:0] ex_a, ex_b, ex_store_data, ex_pc;

    int checks = 0;
    int errors = 0;

    id_issue dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
        .id_instr(id_instr), .id_pc(id_pc), .rs_data(rs_data), .rt_data(rt_data),
        .ex_ready(ex_ready), .flush(flush), .mem_we(mem_we), .mem_wreg(mem_wreg),
`ifdef FORWARD_EN
        .mem_data(mem_data),
`endif
        .ex_valid(ex_valid), .ex_aluop(ex_aluop), .ex_a(ex_a), .ex_b(ex_b),
        .ex_wreg(ex_wreg), .ex_we(ex_we), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
        .ex_store_data(ex_store_data), .ex_branch(ex_branch), .ex_illegal(ex_illegal),
        .ex_pc(ex_pc)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] rsv, input logic [31:0] rtv);
        id_valid = 1'b1;
        id_instr = instr;
        id_pc    = pc;
        rs_data  = rsv;
        rt_data  = rtv;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(32'h01095020, 32'h100, 32'd5, 32'd7);
        tick();
        tick();
        checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL rst_id_ready: got %b want 0", id_ready); end
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", ex_valid); end
        checks++; if (ex_aluop !== 5'd0) begin errors++; $display("FAIL rst_aluop: got %0d want 0", ex_aluop); end
        checks++; if (ex_a !== 32'd0 || ex_b !== 32'd0) begin errors++; $display("FAIL rst_ab: got %h/%h want 0/0", ex_a, ex_b); end
        checks++; if (ex_we !== 1'b0 || ex_pc !== 32'd0) begin errors++; $display("FAIL rst_we_pc: got %b/%h want 0/0", ex_we, ex_pc); end
        rst = 1'b0;
        id_valid = 1'b0;
        tick();
    endtask

    task automatic test_rtype();
        drive(32'h01095020, 32'h100, 32'd5, 32'd7);
        #1;
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL add_ready: got %b want 1", id_ready); end
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_we !== 1'b1) begin errors++; $display("FAIL add_valid_we: got %b/%b want 1/1", ex_valid, ex_we); end
        checks++; if (ex_aluop !== 5'd0) begin errors++; $display("FAIL add_aluop: got %0d want 0", ex_aluop); end
        checks++; if (ex_a !== 32'd5 || ex_b !== 32'd7) begin errors++; $display("FAIL add_ab: got %h/%h want 5/7", ex_a, ex_b); end
        checks++; if (ex_wreg !== 5'd10 || ex_pc !== 32'h100) begin errors++; $display("FAIL add_wreg_pc: got %0d/%h want 10/100", ex_wreg, ex_pc); end
        drive(32'h00041883, 32'h104, 32'd0, 32'h80000000);
        tick();
        checks++; if (ex_aluop !== 5'd4) begin errors++; $display("FAIL sra_aluop: got %0d want 4", ex_aluop); end
        checks++; if (ex_a !== 32'd2 || ex_b !== 32'h80000000) begin errors++; $display("FAIL sra_ab: got %h/%h want 2/80000000", ex_a, ex_b); end
        checks++; if (ex_wreg !== 5'd3 || ex_we !== 1'b1) begin errors++; $display("FAIL sra_wreg: got %0d/%b want 3/1", ex_wreg, ex_we); end
    endtask

    task automatic test_itype();
        drive(32'h30C5FFFF, 32'h108, 32'h12, 32'd0);
        tick();
        checks++; if (ex_aluop !== 5'd5 || ex_b !== 32'h0000FFFF) begin errors++; $display("FAIL andi: got %0d/%h want 5/0000ffff", ex_aluop, ex_b); end
        checks++; if (ex_a !== 32'h12 || ex_wreg !== 5'd5) begin errors++; $display("FAIL andi_a_wreg: got %h/%0d want 12/5", ex_a, ex_wreg); end
        drive(32'h2005FFFF, 32'h10C, 32'd0, 32'd0);
        tick();
        checks++; if (ex_aluop !== 5'd0 || ex_b !== 32'hFFFFFFFF) begin errors++; $display("FAIL addi: got %0d/%h want 0/ffffffff", ex_aluop, ex_b); end
        checks++; if (ex_we !== 1'b1 || ex_wreg !== 5'd5) begin errors++; $display("FAIL addi_we: got %b/%0d want 1/5", ex_we, ex_wreg); end
        id_valid = 1'b0;
        tick();
        checks++; if (ex_valid !== 1'b0 || ex_we !== 1'b0) begin errors++; $display("FAIL idle_bubble: got %b/%b want 0/0", ex_valid, ex_we); end
    endtask

    task automatic test_store_branch();
        drive(32'hAD280004, 32'h110, 32'h40, 32'h55);
        tick();
        checks++; if (ex_mem_wr !== 1'b1 || ex_we !== 1'b0) begin errors++; $display("FAIL sw_ctl: got wr=%b we=%b want 1/0", ex_mem_wr, ex_we); end
        checks++; if (ex_a !== 32'h40 || ex_b !== 32'd4 || ex_store_data !== 32'h55) begin errors++; $display("FAIL sw_data: got %h/%h/%h want 40/4/55", ex_a, ex_b, ex_store_data); end
        drive(32'h10220003, 32'h114, 32'd3, 32'd3);
        tick();
        checks++; if (ex_aluop !== 5'd1 || ex_branch !== 1'b1 || ex_we !== 1'b0) begin errors++; $display("FAIL beq: got %0d/%b/%b want 1/1/0", ex_aluop, ex_branch, ex_we); end
        id_valid = 1'b0;
        tick();
    endtask

    task automatic test_load_use();
        drive(32'h8D280000, 32'h120, 32'h40, 32'd0);
        tick();
        checks++; if (ex_mem_rd !== 1'b1 || ex_wreg !== 5'd8 || ex_a !== 32'h40) begin errors++; $display("FAIL lw_issue: got rd=%b wreg=%0d a=%h want 1/8/40", ex_mem_rd, ex_wreg, ex_a); end
        drive(32'h01095020, 32'h124, 32'd5, 32'd7);
        #1;
        checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL lu_ready1: got %b want 0", id_ready); end
        tick();
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble1: got %b want 0", ex_valid); end
        mem_we   = 1'b1;
        mem_wreg = 5'd8;
`ifdef FORWARD_EN
        mem_data = 32'h1234;
        #1;
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL lu_fwd_ready: got %b want 1", id_ready); end
        tick();
        mem_we = 1'b0;
`else
        #1;
        checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL lu_ready2: got %b want 0", id_ready); end
        tick();
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble2: got %b want 0", ex_valid); end
        mem_we  = 1'b0;
        rs_data = 32'h1234;
        #1;
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL lu_ready3: got %b want 1", id_ready); end
        tick();
`endif
        checks++; if (ex_valid !== 1'b1 || ex_pc !== 32'h124) begin errors++; $display("FAIL lu_issue: got %b/%h want 1/124", ex_valid, ex_pc); end
        checks++; if (ex_a !== 32'h1234 || ex_b !== 32'd7) begin errors++; $display("FAIL lu_ab: got %h/%h want 1234/7", ex_a, ex_b); end
        id_valid = 1'b0;
        tick();
    endtask

    task automatic test_stall();
        drive(32'h01095020, 32'h200, 32'd5, 32'd7);
        tick();
        drive(32'h382200F0, 32'h204, 32'h0F, 32'd0);
        ex_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL stall_ready%0d: got %b want 0", i, id_ready); end
            tick();
            checks++; if (ex_valid !== 1'b1 || ex_pc !== 32'h200 || ex_a !== 32'd5) begin errors++; $display("FAIL stall_hold%0d: got %b/%h/%h want 1/200/5", i, ex_valid, ex_pc, ex_a); end
        end
        ex_ready = 1'b1;
        #1;
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL stall_release: got %b want 1", id_ready); end
        tick();
        checks++; if (ex_aluop !== 5'd7 || ex_b !== 32'hF0 || ex_a !== 32'h0F || ex_pc !== 32'h204) begin errors++; $display("FAIL xori: got %0d/%h/%h/%h want 7/f0/f/204", ex_aluop, ex_b, ex_a, ex_pc); end
    endtask

    task automatic test_flush();
        drive(32'h01095020, 32'h300, 32'd5, 32'd7);
        ex_ready = 1'b0;
        flush    = 1'b1;
        #1;
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b want 1", id_ready); end
        tick();
        checks++; if (ex_valid !== 1'b0 || ex_we !== 1'b0) begin errors++; $display("FAIL flush_kill: got %b/%b want 0/0", ex_valid, ex_we); end
        flush    = 1'b0;
        ex_ready = 1'b1;
        id_valid = 1'b0;
        tick();
    endtask

    task automatic test_illegal();
        drive(32'hFC000000, 32'h400, 32'd9, 32'd9);
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_illegal !== 1'b1) begin errors++; $display("FAIL ill_flag: got %b/%b want 1/1", ex_valid, ex_illegal); end
        checks++; if (ex_we !== 1'b0 || ex_aluop !== 5'd0 || ex_mem_rd !== 1'b0 || ex_branch !== 1'b0) begin errors++; $display("FAIL ill_ctl: got we=%b op=%0d rd=%b br=%b want 0/0/0/0", ex_we, ex_aluop, ex_mem_rd, ex_branch); end
        drive(32'h00000020, 32'h404, 32'd0, 32'd0);
        tick();
        checks++; if (ex_we !== 1'b0 || ex_valid !== 1'b1 || ex_illegal !== 1'b0) begin errors++; $display("FAIL r0_we: got we=%b v=%b ill=%b want 0/1/0", ex_we, ex_valid, ex_illegal); end
    endtask

    task automatic test_mid_reset();
        drive(32'h01095020, 32'h500, 32'd5, 32'd7);
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_pc !== 32'h500) begin errors++; $display("FAIL mr_pre: got %b/%h want 1/500", ex_valid, ex_pc); end
        rst = 1'b1;
        #1;
        checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL mr_ready: got %b want 0", id_ready); end
        tick();
        checks++; if (ex_valid !== 1'b0 || ex_a !== 32'd0 || ex_pc !== 32'd0 || ex_wreg !== 5'd0 || ex_we !== 1'b0) begin errors++; $display("FAIL mr_clear: got v=%b a=%h pc=%h wreg=%0d we=%b want all 0", ex_valid, ex_a, ex_pc, ex_wreg, ex_we); end
        rst = 1'b0;
        id_valid = 1'b0;
        tick();
    endtask

    initial begin
        rst      = 1'b1;
        id_valid = 1'b0;
        id_instr = 32'd0;
        id_pc    = 32'd0;
        rs_data  = 32'd0;
        rt_data  = 32'd0;
        ex_ready = 1'b1;
        flush    = 1'b0;
        mem_we   = 1'b0;
        mem_wreg = 5'd0;
`ifdef FORWARD_EN
        mem_data = 32'd0;
`endif
        test_reset();
        test_rtype();
        test_itype();
        test_store_branch();
        test_load_use();
        test_stall();
        test_flush();
        test_illegal();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
